// File: rtl/alu_pkg.sv
// alu_pkg: shared op encodings, slot states and requester count for the ALU arbiter.
package alu_pkg;
  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_SHIFT = 3'b100,
    ALU_SLT   = 3'b101,
    ALU_PASSB = 3'b110
  } alu_op_e;
  typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_e;
  localparam int NUM_REQ = 2;
endpackage

// File: rtl/alu.sv
// alu: combinational ALU; unsigned SLT, unknown ops yield zero.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 3
) (
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [OP_W-1:0]  ALUControl,
  output logic [WIDTH-1:0] ALUResult
);
  always_comb begin
    ALUResult = ALUControl == OP_W'(ALU_ADD)   ? SrcA + SrcB :
                ALUControl == OP_W'(ALU_SUB)   ? SrcA - SrcB :
                ALUControl == OP_W'(ALU_AND)   ? SrcA & SrcB :
                ALUControl == OP_W'(ALU_OR)    ? SrcA | SrcB :
                ALUControl == OP_W'(ALU_SLT)   ? WIDTH'(SrcA < SrcB) :
                ALUControl == OP_W'(ALU_PASSB) ? SrcB : '0;
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between two valid/ready ports,
// with a single owner-tagged result slot giving one-cycle latency.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_src_a,
  input  logic [WIDTH-1:0] req0_src_b,
  input  logic [OP_W-1:0]  req0_op,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_result,
  output logic             resp0_err,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_src_a,
  input  logic [WIDTH-1:0] req1_src_b,
  input  logic [OP_W-1:0]  req1_op,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_result,
  output logic             resp1_err
);
  slot_state_e      state_q, state_d;
  logic             owner_q, owner_d, rr_q, rr_d, err_q, err_d;
  logic [WIDTH-1:0] result_q, result_d, src_a, src_b, alu_res;
  logic [OP_W-1:0]  op;
  logic             drain, can_accept, g0, g1, gnt, unsup;
  alu #(.WIDTH(WIDTH), .OP_W(OP_W)) u_alu (
    .SrcA(src_a), .SrcB(src_b), .ALUControl(op), .ALUResult(alu_res)
  );
  // rr_q holds the last granted port; on a tie the other port wins.
  always_comb begin
    drain      = state_q == SLOT_FULL && (owner_q ? resp1_ready : resp0_ready);
    can_accept = !rst && (state_q == SLOT_EMPTY || drain);
    g0         = can_accept && req0_valid && (!req1_valid || rr_q);
    g1         = can_accept && req1_valid && (!req0_valid || !rr_q);
    gnt        = g0 || g1;
    src_a      = g1 ? req1_src_a : req0_src_a;
    src_b      = g1 ? req1_src_b : req0_src_b;
    op         = g1 ? req1_op : req0_op;
    unsup      = op == OP_W'(ALU_SHIFT) || &op;
    state_d    = gnt ? SLOT_FULL : drain ? SLOT_EMPTY : state_q;
    owner_d    = gnt ? g1 : owner_q;
    rr_d       = gnt ? g1 : rr_q;
    result_d   = gnt ? (unsup ? '0 : alu_res) : result_q;
    err_d      = gnt ? unsup : err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SLOT_EMPTY;
      owner_q  <= 1'b0;
      rr_q     <= 1'b1;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end
  assign req0_ready   = g0;
  assign req1_ready   = g1;
  assign resp0_valid  = state_q == SLOT_FULL && !owner_q;
  assign resp1_valid  = state_q == SLOT_FULL && owner_q;
  assign resp0_result = result_q;
  assign resp1_result = result_q;
  assign resp0_err    = err_q;
  assign resp1_err    = err_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for the two-port ALU arbiter.
module tb_alu_arbiter;
  logic        clk = 0, rst = 1;
  logic        req0_valid = 0, req0_ready, resp0_valid, resp0_ready = 0, resp0_err;
  logic        req1_valid = 0, req1_ready, resp1_valid, resp1_ready = 0, resp1_err;
  logic [31:0] req0_src_a = 0, req0_src_b = 0, req1_src_a = 0, req1_src_b = 0;
  logic [31:0] resp0_result, resp1_result;
  logic [2:0]  req0_op = 0, req1_op = 0;
  int n_checks = 0, n_fail = 0;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_src_a(req0_src_a),
    .req0_src_b(req0_src_b), .req0_op(req0_op), .resp0_valid(resp0_valid),
    .resp0_ready(resp0_ready), .resp0_result(resp0_result), .resp0_err(resp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_src_a(req1_src_a),
    .req1_src_b(req1_src_b), .req1_op(req1_op), .resp1_valid(resp1_valid),
    .resp1_ready(resp1_ready), .resp1_result(resp1_result), .resp1_err(resp1_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; req0_valid = 0; req1_valid = 0; resp0_ready = 0; resp1_ready = 0;
    step();
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; req0_valid = 1; req1_valid = 1;
    step();
    step();
    #2;
    n_checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
    end
    n_checks++;
    if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b%b want 00", resp0_valid, resp1_valid);
    end
    n_checks++;
    if (resp0_result !== 32'h0 || resp0_err !== 1'b0 || resp1_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_result: got %h err %b%b want 0", resp0_result, resp0_err, resp1_err);
    end
    req0_valid = 0; req1_valid = 0;
    step();
    rst = 0;
  endtask

  task automatic test_single();
    req0_src_a = 5; req0_src_b = 3; req0_op = 3'b001; req0_valid = 1; resp0_ready = 1;
    #2;
    n_checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL single_ready: got %b%b want 10", req0_ready, req1_ready);
    end
    step();
    req0_valid = 0;
    #2;
    n_checks++;
    if (resp0_valid !== 1'b1 || resp0_result !== 32'd2 || resp0_err !== 1'b0 || resp1_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_resp: got v%b r%h e%b v1%b want v1 r2 e0 v1 0",
                         resp0_valid, resp0_result, resp0_err, resp1_valid);
    end
    step();
    #2;
    n_checks++;
    if (resp0_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_drain: got %b want 0", resp0_valid);
    end
  endtask

  task automatic test_contention();
    logic exp_g;
    do_reset();
    req0_src_a = 1; req0_src_b = 1; req0_op = 3'b000;
    req1_src_a = 32'hF0F0_F0F0; req1_src_b = 32'hFF00_FF00; req1_op = 3'b010;
    req0_valid = 1; req1_valid = 1; resp0_ready = 1; resp1_ready = 1;
    for (int i = 0; i < 4; i++) begin
      exp_g = i[0];
      #2;
      n_checks++;
      if (req0_ready !== !exp_g || req1_ready !== exp_g) begin
        n_fail++; $display("FAIL contention_grant[%0d]: got %b%b want grant port %0d", i, req0_ready, req1_ready, exp_g);
      end
      if (i > 0) begin
        n_checks++;
        if (exp_g ? (resp0_valid !== 1'b1 || resp1_valid !== 1'b0 || resp0_result !== 32'd2)
                  : (resp1_valid !== 1'b1 || resp0_valid !== 1'b0 || resp1_result !== 32'hF000_F000)) begin
          n_fail++; $display("FAIL contention_resp[%0d]: got v%b%b r%h/%h", i, resp0_valid, resp1_valid, resp0_result, resp1_result);
        end
      end
      step();
    end
    req0_valid = 0; req1_valid = 0;
    #2;
    n_checks++;
    if (resp1_valid !== 1'b1 || resp1_result !== 32'hF000_F000) begin
      n_fail++; $display("FAIL contention_last: got v%b r%h want 1 f000f000", resp1_valid, resp1_result);
    end
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    req1_src_a = 0; req1_src_b = 32'hDEAD_BEEF; req1_op = 3'b110; req1_valid = 1;
    #2;
    n_checks++;
    if (req1_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_grant1: got %b want 1", req1_ready);
    end
    step();
    req1_valid = 0; req0_src_a = 7; req0_src_b = 8; req0_op = 3'b000; req0_valid = 1; resp0_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #2;
      n_checks++;
      if (req0_ready !== 1'b0 || resp1_valid !== 1'b1 || resp1_result !== 32'hDEAD_BEEF) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got rdy0 %b v1 %b r %h want 0 1 deadbeef", i, req0_ready, resp1_valid, resp1_result);
      end
      step();
    end
    resp1_ready = 1;
    #2;
    n_checks++;
    if (req0_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: got %b want 1", req0_ready);
    end
    step();
    req0_valid = 0;
    #2;
    n_checks++;
    if (resp0_valid !== 1'b1 || resp1_valid !== 1'b0 || resp0_result !== 32'd15) begin
      n_fail++; $display("FAIL bp_after: got v%b%b r%h want 10 f", resp0_valid, resp1_valid, resp0_result);
    end
    step();
  endtask

  task automatic test_arith();
    logic [31:0] va [6] = '{32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h3, 32'h3};
    logic [31:0] vb [6] = '{32'h1, 32'h1, 32'h1, 32'h2, 32'h4, 32'h4};
    logic [2:0]  vo [6] = '{3'b000, 3'b001, 3'b101, 3'b101, 3'b100, 3'b111};
    logic [31:0] ve [6] = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h0, 32'h0};
    logic        vr [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    resp0_ready = 1;
    for (int i = 0; i < 6; i++) begin
      req0_src_a = va[i]; req0_src_b = vb[i]; req0_op = vo[i]; req0_valid = 1;
      #2;
      n_checks++;
      if (req0_ready !== 1'b1) begin
        n_fail++; $display("FAIL arith_ready[%0d]: got %b want 1", i, req0_ready);
      end
      step();
      req0_valid = 0;
      #2;
      n_checks++;
      if (resp0_valid !== 1'b1 || resp0_result !== ve[i] || resp0_err !== vr[i]) begin
        n_fail++; $display("FAIL arith_resp[%0d]: got v%b r%h e%b want v1 r%h e%b", i, resp0_valid, resp0_result, resp0_err, ve[i], vr[i]);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req0_src_a = 1; req0_src_b = 2; req0_op = 3'b000; req0_valid = 1; resp0_ready = 0;
    step();
    req0_valid = 0;
    #2;
    n_checks++;
    if (resp0_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_pending: got %b want 1", resp0_valid);
    end
    rst = 1;
    step();
    rst = 0;
    #2;
    n_checks++;
    if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_discard: got %b%b want 00", resp0_valid, resp1_valid);
    end
    req0_valid = 1; req1_valid = 1; resp0_ready = 1; resp1_ready = 1;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_rr: got %b%b want 10", req0_ready, req1_ready);
    end
    step();
    req0_valid = 0; req1_valid = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_arith();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU between two requesters, e.g. the core execute path (port 0) and a branch-target/debug unit (port 1).
- Each port uses a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin. One-cycle latency through a single registered result slot tagged with its owner.
- Sits between the requesters and the `alu` instance it wraps.

Parameters:
- WIDTH, 32, operand/result width
- OP_W, 3, ALU operation code width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req0_valid  in  1  port 0 request valid
- req0_ready  out  1  port 0 request accepted this cycle
- req0_src_a  in  WIDTH  port 0 operand A
- req0_src_b  in  WIDTH  port 0 operand B
- req0_op  in  OP_W  port 0 ALU operation
- resp0_valid  out  1  port 0 result valid
- resp0_ready  in  1  port 0 consumes result
- resp0_result  out  WIDTH  port 0 result
- resp0_err  out  1  port 0 op was unsupported
- req1_valid, req1_ready, req1_src_a, req1_src_b, req1_op: as port 0, for port 1
- resp1_valid, resp1_ready, resp1_result, resp1_err: as port 0, for port 1

Behaviour:
- Clock and reset: one clock `clk`; `rst` synchronous, active-high.
- Reset values: resp*_valid=0, resp*_result=0, resp*_err=0, slot state EMPTY, rr pointer=1 (port 0 wins the first tie). req*_ready=0 while rst is high.
- Slot FSM, two states:
  - EMPTY: a grant moves to FULL.
  - FULL, drain with no new grant: moves to EMPTY.
  - FULL, drain plus new grant in the same cycle: stays FULL with the new owner (back-to-back, no bubble).
- can_accept = (state==EMPTY) | (owner's resp_valid & resp_ready). Combinational.
- Grant, combinational, at most one per cycle:
  - Only one reqX_valid & can_accept: grant X.
  - Both valid & can_accept: grant the port != rr pointer.
- reqX_ready = grant to X. It may depend on the other port's valid. reqX_ready never goes high without reqX_valid.
- Updates at the grant edge:
  - Operands and op of the granted port drive the ALU.
  - Result, err and owner are registered; rr pointer ← granted port.
- Latency: request accepted at edge N → respX_valid high in cycle N+1.
- respX_valid = FULL & owner==X. The non-owner's resp_valid is 0.
- Result and err stay stable while valid & !ready.
- Requester rule: hold valid, operands and op stable until ready. Dropping valid before ready is legal, and no transaction occurs.
- Op encoding (unsigned arithmetic, wrap mod 2^WIDTH):
  - 000 ADD, 001 SUB, 010 AND, 011 OR.
  - 101 SLT: unsigned A<B → 1 else 0.
  - 110 PASSB.
- Unsupported ops 100 (shift, reserved) and 111: result 0, err 1. The response is still delivered with normal handshake timing.
- Fairness: with both ports continuously valid and responses consumed every cycle, grants strictly alternate 0,1,0,1…
- No starvation: a waiting port is granted within 2 slot drains.
- Backpressure: an owner holding resp_ready=0 blocks both ports. No grant occurs until it drains.
- Simultaneous events:
  - Drain and grant in the same cycle are allowed.
  - A port whose own response is draining may be re-granted the same cycle, subject to rr.
- Reset mid-operation: a pending result is discarded without a response. The rr pointer returns to 1.

Decomposition:
- Package alu_pkg:
  - alu_op_e enum: ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011, ALU_SHIFT=100 (reserved), ALU_SLT=101, ALU_PASSB=110.
  - slot_state_e {SLOT_EMPTY, SLOT_FULL}.
  - Localparam NUM_REQ=2.
- Sub-module: one instance of the existing `alu` (SrcA, SrcB, ALUControl → ALUResult). Operand muxing, unsupported-op detection and all sequential logic stay in alu_arbiter.

Test Plan:
- Reset then single request: port 0 req A=5, B=3, op=001 → req0_ready=1 same cycle; next cycle resp0_valid=1, result=2, err=0; resp1_valid=0.
- Contention: both valid from reset, port 0 ADD 1+1, port 1 AND 0xF0F0_F0F0 & 0xFF00_FF00, resp_ready held 1 → grant order 0,1,0,1; port 0 result 2; port 1 result 0xF000_F000; one response per cycle, no bubbles.
- Backpressure: port 1 owns slot with PASSB B=0xDEAD_BEEF and holds resp1_ready=0 for 4 cycles while port 0 valid → req0_ready=0 for those cycles; result stable at 0xDEAD_BEEF; port 0 granted in the cycle resp1_ready=1.
- Arithmetic edges: ADD 0xFFFF_FFFF+1 → 0; SUB 0-1 → 0xFFFF_FFFF; SLT A=0xFFFF_FFFF, B=1 → 0 (unsigned); SLT A=1, B=2 → 1.
- Unsupported op: op=100 then op=111 → result 0, err=1, normal one-cycle timing.
- Reset mid-operation: grant port 0, assert rst for 1 cycle while resp0_ready=0 → resp0_valid=0 after the reset edge; next tie grants port 0 first.
